// File: rtl/bht_btb_predictor.sv
// bht_btb_predictor
// Direct-mapped branch predictor for the IF stage: a table of saturating
// direction counters merged with a tagged branch-target buffer. Lookup is
// combinational (zero latency); training comes from EX one update per clock.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous active-low reset; clears the whole table
//   flush           synchronous clear of all valid bits (ctr/target kept)
//   lookup_pc       fetch PC
//   predict_hit     entry at lookup index is valid and its tag matches
//   predict_taken   hit and counter MSB set
//   predict_target  stored target when predicted taken, else lookup_pc+4
//   ctr_state       counter at lookup index, regardless of hit
//   upd_valid       resolved-branch update strobe
//   upd_pc          PC of the resolved branch
//   upd_taken       actual outcome
//   upd_target      actual taken target
//   mispredict      update disagrees with the (pre-update) table contents
//   mispred_count   saturating count of mispredictions
module bht_btb_predictor #(
    parameter int ADDR_W   = 32,
    parameter int IDX_BITS = 4,
    parameter int TAG_BITS = 6,
    parameter int CTR_BITS = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              predict_hit,
    output logic              predict_taken,
    output logic [ADDR_W-1:0] predict_target,
    output logic [CTR_BITS-1:0] ctr_state,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    output logic              mispredict,
    output logic [CNT_W-1:0]  mispred_count
);

    localparam int ENTRIES = 2 ** IDX_BITS;
    localparam logic [ADDR_W-1:0]   PC_STEP = ADDR_W'(4);
    localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    // weakly taken: MSB set, all lower bits clear
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_ONE << (CTR_BITS - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX = '1;

    logic [ENTRIES-1:0]                valid_q, valid_d;
    logic [ENTRIES-1:0][TAG_BITS-1:0]  tag_q,   tag_d;
    logic [ENTRIES-1:0][CTR_BITS-1:0]  ctr_q,   ctr_d;
    logic [ENTRIES-1:0][ADDR_W-1:0]    tgt_q,   tgt_d;
    logic [CNT_W-1:0]                  cnt_q,   cnt_d;

    // lookup side
    logic [IDX_BITS-1:0] l_idx;
    logic [TAG_BITS-1:0] l_tag;
    assign l_idx = lookup_pc[IDX_BITS+1:2];
    assign l_tag = lookup_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

    assign predict_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign predict_taken  = predict_hit && ctr_q[l_idx][CTR_BITS-1];
    assign predict_target = predict_taken ? tgt_q[l_idx] : (lookup_pc + PC_STEP);
    assign ctr_state      = ctr_q[l_idx];

    // update side, evaluated against the registered (old) table
    logic [IDX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0] u_tag;
    logic                u_hit, u_pred_taken;
    assign u_idx        = upd_pc[IDX_BITS+1:2];
    assign u_tag        = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign u_hit        = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_pred_taken = u_hit && ctr_q[u_idx][CTR_BITS-1];

    assign mispredict = upd_valid &&
                        ((upd_taken != u_pred_taken) ||
                         (upd_taken && u_pred_taken && (tgt_q[u_idx] != upd_target)));

    assign mispred_count = cnt_q;

    // only the index/tag field of upd_pc matters
    logic unused_upd_pc;
    assign unused_upd_pc = ^upd_pc;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        ctr_d   = ctr_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;

        // counted even when a flush drops the update
        if (mispredict && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_ONE;

        if (flush) begin
            valid_d = '0;
        end else if (upd_valid) begin
            if (u_hit) begin
                if (upd_taken) begin
                    if (ctr_q[u_idx] != CTR_MAX)
                        ctr_d[u_idx] = ctr_q[u_idx] + CTR_ONE;
                    tgt_d[u_idx] = upd_target;
                end else if (ctr_q[u_idx] != '0) begin
                    ctr_d[u_idx] = ctr_q[u_idx] - CTR_ONE;
                end
            end else if (upd_taken) begin
                // allocate / replace on a taken miss
                valid_d[u_idx] = 1'b1;
                tag_d[u_idx]   = u_tag;
                ctr_d[u_idx]   = CTR_WT;
                tgt_d[u_idx]   = upd_target;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            tag_q   <= '0;
            ctr_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            ctr_q   <= ctr_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/bht_btb_predictor.md
Name: bht_btb_predictor

Overview:
- Parametrised branch predictor. It combines a direct-mapped table of saturating direction counters with a tagged branch-target buffer.
- It sits in the IF stage: gives a taken/not-taken prediction and a target for the fetch PC in the same cycle.
- It is trained from EX with the resolved branch outcome.
- Adds tags, valid bits, stored targets, configurable depth and counter width, flush, and a misprediction counter.

Parameters:
ADDR_W, 32, PC width
IDX_BITS, 4, index bits; ENTRIES = 2**IDX_BITS
TAG_BITS, 6, tag bits stored per entry
CTR_BITS, 2, saturating counter width (>=1)
CNT_W, 16, misprediction counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of all valid bits
lookup_pc  in  ADDR_W  fetch PC
predict_hit  out  1  lookup entry valid and tag matches
predict_taken  out  1  predicted taken
predict_target  out  ADDR_W  next-fetch PC
ctr_state  out  CTR_BITS  counter value at lookup index
upd_valid  in  1  resolved-branch update strobe (from ID/EX)
upd_pc  in  ADDR_W  PC of the resolved branch
upd_taken  in  1  actual outcome
upd_target  in  ADDR_W  actual taken target
mispredict  out  1  combinational: the current update disagrees with the table
mispred_count  out  CNT_W  saturating count of mispredictions

Behaviour:
- Index is pc[IDX_BITS+1:2]. Tag is pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
- Lookup is combinational, with zero latency:
  - predict_hit = valid[idx] & (tag[idx]==lookup tag).
  - predict_taken = predict_hit & ctr[idx][CTR_BITS-1].
  - predict_target = stored target if predict_taken, else lookup_pc+4 (mod 2**ADDR_W).
  - ctr_state = ctr[idx], regardless of hit.
- mispredict is evaluated against pre-update table contents at upd_pc:
  - It is 1 when upd_valid and (upd_taken != upd-side predicted taken).
  - It is also 1 when upd_valid, upd_taken, predicted taken, and stored target != upd_target.
- Update happens on rising clk when upd_valid=1:
  - Hit, taken: ctr increments, saturating at all-ones; target <= upd_target.
  - Hit, not taken: ctr decrements, saturating at 0; target unchanged.
  - Miss, taken: allocate or replace the entry. valid<=1, tag<=upd tag, ctr<=weakly taken (1<<(CTR_BITS-1)), target<=upd_target.
  - Miss, not taken: no change.
- mispred_count increments when mispredict=1 and holds at all-ones.
- Same-cycle lookup and update to the same index: lookup sees the old contents, with no bypass. The new value is visible from the next cycle.
- flush=1 at a clock edge clears all valid bits.
  - Counters and targets are retained.
  - mispred_count is retained.
  - flush has priority over a simultaneous upd_valid; that update is dropped, but mispred_count still counts it.
- Reset (reset=0) acts immediately, without waiting for clk, and holds while low:
  - All valid bits = 0, all ctr = 0, all targets = 0, mispred_count = 0.
  - Resulting outputs: predict_hit=0, predict_taken=0, predict_target=lookup_pc+4, ctr_state=0.
  - The first update is accepted on the first rising edge after reset goes high.
- Storage is clocked registers only. No table write occurs outside a clk edge, except reset.

Test Plan:
- Defaults throughout, with CNT_W=4 for scenario 5. PC 0x40 → idx 0, tag 1.
1. Release reset, lookup 0x40 → hit=0, taken=0, target=0x44, ctr_state=0.
2. Update pc=0x40, taken, target=0x100; mispredict=1 during that cycle → next cycle lookup 0x40 gives hit=1, taken=1, target=0x100, ctr_state=2'b10, mispred_count=1.
3. Three more taken updates on 0x40 → ctr 11, holding at 11. Then two not-taken updates → 10 then 01, taken=0, hit=1, target=0x44.
4. Aliasing: taken update pc=0x80 (idx 0, tag 2, target 0x200) → lookup 0x40 hit=0; lookup 0x80 hit=1, target 0x200, ctr 10.
5. 17 consecutive mispredicting updates (not-taken on a strongly-taken entry, alternating) → mispred_count reaches 15 and holds.
6. Assert reset between clk edges mid-stream → outputs are reset values before the next edge. Then flush with a simultaneous taken update on 0x40 → hit=0 next cycle; ctr_state shows the retained value.
